// File: rtl/ram_pattern_tester.sv
// ram_pattern_tester: fills a block RAM with a selectable pattern, reads it back
// for a programmable number of passes and records mismatch statistics
// (saturating count, sticky flag, first failing address and data).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; results of the last test are held
// S_WRITE | writing p(address) to every address, one per cycle
// S_READ  | reading every address each pass, compares launched
// S_FLUSH | RD_LAT cycles letting in-flight compares retire
// S_DONE  | one-cycle done pulse, then back to idle
module ram_pattern_tester #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        passes,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  output logic [DATA_W-1:0] data_to_write,
  input  logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              error_flag,
  output logic [ERR_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] first_fail_data
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;
  localparam logic [ERR_W-1:0]  ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        FLUSH_INIT = 3'(RD_LAT - 1);

  // Expected word for address a under pattern m.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0]        cb;
    logic [DATA_W+ADDR_W-1:0] ext;
    logic [DATA_W-1:0]        res;
    // MSB-first 1010... on even addresses, inverted on odd ones
    for (int i = 0; i < DATA_W; i++) cb[i] = (((DATA_W - 1 - i) % 2) == 0) ^ a[0];
    ext = {{DATA_W{1'b0}}, a};
    case (m)
      2'd0:    res = cb;
      2'd1:    res = ~cb;
      2'd2:    res = ext[DATA_W-1:0];
      default: res = {{(DATA_W-1){1'b0}}, 1'b1} << (int'(a) % DATA_W);
    endcase
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          pass_left_q, pass_left_d;
  logic [2:0]          flush_q, flush_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [DATA_W-1:0]   exp_q [RD_LAT];
  logic [DATA_W-1:0]   exp_d [RD_LAT];
  logic [ADDR_W-1:0]   paddr_q [RD_LAT];
  logic [ADDR_W-1:0]   paddr_d [RD_LAT];
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                err_flag_q, err_flag_d;
  logic [ADDR_W-1:0]   ffa_q, ffa_d;
  logic [DATA_W-1:0]   ffd_q, ffd_d;
  logic                clear_res;
  logic                mismatch;
  logic [DATA_W-1:0]   cur_pat;

  assign cur_pat = pattern(mode_q, addr_q);

  // Sequencer: next state, address walk, pass and flush counters.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    pass_left_d = pass_left_q;
    flush_d     = flush_q;
    clear_res   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WRITE;
          addr_d      = '0;
          mode_d      = mode;
          pass_left_d = (passes == 8'd0) ? 8'd1 : passes;
          clear_res   = 1'b1;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_ONE;
        if (addr_q == ADDR_MAX) state_d = S_READ;
      end
      S_READ: begin
        addr_d = addr_q + ADDR_ONE;
        if (addr_q == ADDR_MAX) begin
          if (pass_left_q == 8'd1) begin
            state_d = S_FLUSH;
            flush_d = FLUSH_INIT;
          end else begin
            pass_left_d = pass_left_q - 8'd1;
          end
        end
      end
      S_FLUSH: begin
        if (flush_q == 3'd0) state_d = S_DONE;
        else                 flush_d = flush_q - 3'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Compare pipeline: valid, expected word and address travel alongside the RAM read.
  always_comb begin
    vld_d[0]   = (state_q == S_READ);
    exp_d[0]   = cur_pat;
    paddr_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      exp_d[i]   = exp_q[i-1];
      paddr_d[i] = paddr_q[i-1];
    end
  end

  assign mismatch = vld_q[RD_LAT-1] && (q != exp_q[RD_LAT-1]);

  // Result bookkeeping: cleared on an accepted start, updated on each mismatch.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    ffa_d      = ffa_q;
    ffd_d      = ffd_q;
    if (clear_res) begin
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
      ffa_d      = '0;
      ffd_d      = '0;
    end else if (mismatch) begin
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
      err_flag_d = 1'b1;
      if (!err_flag_q) begin
        ffa_d = paddr_q[RD_LAT-1];
        ffd_d = q;
      end
    end
  end

  // All state registers; reset aborts any test and zeroes results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mode_q      <= '0;
      pass_left_q <= '0;
      flush_q     <= '0;
      vld_q       <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i]   <= '0;
        paddr_q[i] <= '0;
      end
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      ffa_q      <= '0;
      ffd_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      pass_left_q <= pass_left_d;
      flush_q     <= flush_d;
      vld_q       <= vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i]   <= exp_d[i];
        paddr_q[i] <= paddr_d[i];
      end
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      ffa_q      <= ffa_d;
      ffd_q      <= ffd_d;
    end
  end

  assign address         = addr_q;
  assign wren            = (state_q == S_WRITE);
  assign data_to_write   = (state_q == S_WRITE) ? cur_pat : '0;
  assign busy            = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_FLUSH);
  assign done            = (state_q == S_DONE);
  assign error_flag      = err_flag_q;
  assign error_count     = err_cnt_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_data = ffd_q;

endmodule

// File: tb/tb_ram_pattern_tester.sv
// Bench for ram_pattern_tester: four builds (default, ERR_W=4, RD_LAT=1,
// RD_LAT=4) run side by side, each with its own RAM model.
module tb_ram_pattern_tester;
  localparam int N = 1024;

  typedef struct {
    int start_cyc;
    int md;
    int p;
    int ec;
    int flag;
    int ffa;
    int ffd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] passes = 8'd0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb [4][$];
  int         flt_stuck = 0;
  int         flt_addr = -1;
  int         flt_mask = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pat(input int md, input int a);
    case (md)
      0:       return (a % 2 == 0) ? 'hAA : 'h55;
      1:       return (a % 2 == 0) ? 'h55 : 'hAA;
      2:       return a % 256;
      default: return 1 << (a % 8);
    endcase
  endfunction

  function automatic int ram_rd(input int v, input int a);
    if (flt_stuck != 0) return 0;
    return (a == flt_addr) ? (v ^ flt_mask) : v;
  endfunction

  function automatic exp_t ref_model(input int g, input int md, input int ps, input int s);
    exp_t e;
    int   cnt;
    int   lim;
    int   good;
    int   seen;
    cnt = 0;
    e.start_cyc = s;
    e.md = md;
    e.p = (ps == 0) ? 1 : ps;
    e.ffa = 0;
    e.ffd = 0;
    for (int a = 0; a < N; a++) begin
      good = pat(md, a);
      seen = ram_rd(good, a);
      if (seen != good) begin
        if (cnt == 0) begin
          e.ffa = a;
          e.ffd = seen;
        end
        cnt++;
      end
    end
    lim = (g == 1) ? 15 : 65535;
    e.ec = (cnt * e.p > lim) ? lim : cnt * e.p;
    e.flag = (cnt != 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", nm, g, act, want, cyc);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int LAT = (g == 2) ? 1 : (g == 3) ? 4 : 2;
    localparam int EW  = (g == 1) ? 4 : 16;

    logic [9:0]    address;
    logic          wren;
    logic [7:0]    dtw;
    logic [7:0]    q;
    logic          busy;
    logic          done;
    logic          eflag;
    logic [EW-1:0] ec;
    logic [9:0]    ffa;
    logic [7:0]    ffd;
    logic [7:0]    mem [N];
    logic [7:0]    rp [LAT];
    exp_t          last;

    ram_pattern_tester #(.DATA_W(8), .ADDR_W(10), .RD_LAT(LAT), .ERR_W(EW)) dut (
      .clk(clk), .reset(rst), .start(start), .mode(mode), .passes(passes),
      .address(address), .wren(wren), .data_to_write(dtw), .q(q),
      .busy(busy), .done(done), .error_flag(eflag), .error_count(ec),
      .first_fail_addr(ffa), .first_fail_data(ffd)
    );

    // RAM model: synchronous write, LAT-cycle read with optional fault
    assign q = rp[LAT-1];
    always @(posedge clk) begin
      if (wren) mem[address] <= dtw;
      rp[0] <= 8'(ram_rd(int'(mem[address]), int'(address)));
      for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end

    // reset drops any test in flight and must zero every output at once
    always @(posedge rst) begin
      sb[g].delete();
      last = '{default: 0};
      #1;
      chk("rst_outputs", g, {address, wren, dtw, busy, done, eflag, 16'(ec), ffa, ffd}, 64'd0);
    end

    // monitor: per-cycle port behaviour, results compared when done appears
    always @(negedge clk) begin : mon
      exp_t e;
      int   k;
      int   dn;
      bit   wr;
      bit   rd;
      if (!rst) begin
        if (sb[g].size() != 0 && cyc > sb[g][0].start_cyc) begin
          e  = sb[g][0];
          k  = cyc - e.start_cyc;
          dn = N * (1 + e.p) + LAT + 1;
          wr = (k <= N);
          rd = (k > N) && (k <= N + N * e.p);
          chk("busy", g, busy, k < dn);
          chk("wren", g, wren, wr);
          if (wr) begin
            chk("wr_addr", g, address, k - 1);
            chk("wr_data", g, dtw, pat(e.md, k - 1));
          end else begin
            chk("dtw_zero", g, dtw, 0);
          end
          if (rd) chk("rd_addr", g, address, (k - N - 1) % N);
          if (done || k > dn + 8) begin
            chk("done_cycle", g, k, dn);
            chk("error_count", g, ec, e.ec);
            chk("error_flag", g, eflag, e.flag);
            chk("first_fail_addr", g, ffa, e.ffa);
            chk("first_fail_data", g, ffd, e.ffd);
            last = e;
            void'(sb[g].pop_front());
          end
        end else begin
          chk("idle_busy", g, busy, 0);
          chk("idle_done", g, done, 0);
          chk("idle_wren", g, wren, 0);
          chk("idle_dtw", g, dtw, 0);
          chk("hold_count", g, ec, last.ec);
          chk("hold_flag", g, eflag, last.flag);
          chk("hold_ffa", g, ffa, last.ffa);
          chk("hold_ffd", g, ffd, last.ffd);
        end
      end
    end
  end

  task automatic launch(input int md, input int ps, output int s);
    @(negedge clk);
    mode   = 2'(md);
    passes = 8'(ps);
    start  = 1'b1;
    s      = cyc;
    for (int g = 0; g < 4; g++) sb[g].push_back(ref_model(g, md, ps, s));
    @(negedge clk);
    start  = 1'b0;
    mode   = 2'($urandom);
    passes = 8'($urandom);
  endtask

  task automatic pulse_start_at(input int when);
    while (cyc < when) @(negedge clk);
    start  = 1'b1;
    mode   = 2'($urandom);
    passes = 8'($urandom_range(1, 9));
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: results still pending after %0d cycles", n);
      for (int g = 0; g < 4; g++) sb[g].delete();
    end
  endtask

  initial begin
    int s;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // fault-free checkerboard, single pass
    flt_stuck = 0; flt_addr = -1; flt_mask = 0;
    launch(0, 1, s);
    wait_idle();

    // bit 3 flipped on every read of address 5, three passes
    flt_addr = 5; flt_mask = 'h08;
    launch(0, 3, s);
    wait_idle();

    // stuck-at-0 RAM with walking ones: saturates the narrow counter
    flt_addr = -1; flt_mask = 0; flt_stuck = 1;
    launch(3, 2, s);
    wait_idle();

    // address-as-data, with start pulses during WRITE and READ ignored
    flt_stuck = 0;
    launch(2, 1, s);
    pulse_start_at(s + 500);
    pulse_start_at(s + 1500);
    wait_idle();

    // reset at write address 300, then a fresh run with a fault at the last address
    launch(1, 1, s);
    while (cyc < s + 301) @(negedge clk);
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    repeat (2) @(negedge clk);
    flt_addr = 'h3FF; flt_mask = 'h01;
    launch(1, 0, s);
    wait_idle();

    // randomized patterns, pass counts and faults
    for (int t = 0; t < 3; t++) begin
      flt_stuck = ($urandom_range(0, 3) == 0) ? 1 : 0;
      flt_addr  = $urandom_range(0, N - 1);
      flt_mask  = $urandom_range(1, 255);
      launch($urandom_range(0, 3), $urandom_range(0, 3), s);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_pattern_tester.md
# ram_pattern_tester

Parametrised single-clock RAM self-test engine for characterising on-chip block RAM. It fills the whole address range with a selectable data pattern, then reads the range back for a programmable number of passes, comparing every word against the expected value. It counts mismatches with a saturating counter and captures the first failing address and data. It drives the RAM port directly and sits between the board-level start/result logic and the RAM under test.

## Interface

- DATA_W, 8, RAM word width (≥2)
- ADDR_W, 10, RAM address width; depth = 2^ADDR_W
- RD_LAT, 2, RAM read latency in clk cycles from address to q (1..4)
- ERR_W, 16, error counter width

- clk  input  1  single clock for block and RAM
- reset  input  1  asynchronous, active-high reset
- start  input  1  level-sampled; begins a test when in IDLE
- mode  input  2  pattern select, latched at start
- passes  input  8  read passes, latched at start; 0 is treated as 1
- address  output  ADDR_W  RAM address
- wren  output  1  RAM write enable
- data_to_write  output  DATA_W  RAM write data
- q  input  DATA_W  RAM read data
- busy  output  1  high from WRITE through FLUSH
- done  output  1  one-cycle pulse at test end
- error_flag  output  1  sticky; set on any mismatch in current test
- error_count  output  ERR_W  mismatch count, saturating at all-ones
- first_fail_addr  output  ADDR_W  address of first mismatch
- first_fail_data  output  DATA_W  q value of first mismatch

## Operation

- Expected pattern p(a) depends on mode:
  - 0: checkerboard. Even a → {1010…}; odd a → {0101…}.
  - 1: inverse checkerboard (~mode 0).
  - 2: address-as-data. a zero-extended or truncated to DATA_W.
  - 3: walking one. 1 << (a mod DATA_W).
- States:
  - IDLE: wren=0, busy=0. On start=1: latch mode and passes, clear error_count, error_flag, first_fail_*, go to WRITE.
  - WRITE: address runs 0..2^ADDR_W−1, one per cycle; wren=1; data_to_write=p(address). After the last address, go to READ with address 0.
  - READ: wren=0; address runs 0..max, one per cycle. It wraps to 0 with no bubble between passes. A pass counter tracks passes. After the last address of the last pass, go to FLUSH.
  - FLUSH: wren=0, held for RD_LAT cycles so outstanding compares retire. Then go to DONE.
  - DONE: done=1, busy=0 for one cycle. Then go to IDLE.
- Compare pipeline: each READ address launches a valid bit and p(address) down an RD_LAT-deep shift register. When the valid bit emerges, q is compared to the delayed expected value.
- On mismatch:
  - error_count increments unless it is all-ones.
  - error_flag is set.
  - If this is the first mismatch of the test, first_fail_addr and first_fail_data are captured. The delayed address is carried in the pipeline for this.
- start is ignored outside IDLE. Results hold after DONE until the next accepted start.
- data_to_write is 0 outside WRITE.

## Timing

- Reset (async assert, sync release): state=IDLE; all outputs 0; compare pipeline cleared.
- Reset during any state aborts the test. Partial results are discarded (zeroed).
- Cycle 0 samples start=1 in IDLE. Cycle 1 is the first WRITE cycle (address=0, wren=1).
- Let N = 2^ADDR_W and P = max(passes,1).
- WRITE occupies cycles 1..N.
- READ occupies cycles N+1..N+N·P.
- FLUSH occupies RD_LAT cycles.
- done pulses at cycle N(1+P)+RD_LAT+1.
- The final compare result is visible on outputs in the done cycle.
- The mismatch update is registered: error_count changes one cycle after the compare cycle.

## Test plan

- Fault-free RAM model, defaults, mode 0, passes=1, start at cycle 0. Required: done exactly at cycle 2051; error_count=0; error_flag=0; busy high for cycles 1..2050.
- Fault model flips bit 3 on every read of address 5, mode 0, passes=3. Required: error_count=3; first_fail_addr=5; first_fail_data=0x5D; error_flag=1.
- ERR_W=4, RAM stuck-at-0, mode 3, passes=2. Required: error_count=15 (saturated, no wrap); first_fail_addr=0; first_fail_data=0x00.
- Mode 2 with DATA_W=8: write data at address 0x1FF must be 0xFF. Pulse start again while busy: the pulse is ignored, the run completes normally, and wren is never asserted during READ.
- Reset asserted mid-WRITE at address 300: all outputs are 0 asynchronously. A following start runs a complete fresh test from address 0.
- RD_LAT=1 and RD_LAT=4 builds with a matching RAM model, one fault at the last address 0x3FF, passes=1. Required: the fault is detected in both builds (first_fail_addr=0x3FF); done timing matches the formula.
